// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources,
// with one registered output stage and a bypass view of the in-flight write.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [32*NREQ-1:0] req_pc,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [4:0]         rf_a3,
  output logic [31:0]        rf_wd,
  output logic [31:0]        rf_pc,
  input  logic [4:0]         byp_a1,
  input  logic [4:0]         byp_a2,
  output logic               byp_hit1,
  output logic               byp_hit2,
  output logic [31:0]        byp_data
);

  logic [IDXW-1:0] r_rr_ptr;
  logic            r_we;
  logic [4:0]      r_a3;
  logic [31:0]     r_wd;
  logic [31:0]     r_pc;

  logic [IDXW-1:0] w_hi_idx;
  logic [IDXW-1:0] w_lo_idx;
  logic [IDXW-1:0] w_gnt_idx;
  logic [IDXW-1:0] w_nxt_ptr;
  logic            w_hi_found;
  logic            w_lo_found;
  logic            w_xfer;
  logic [4:0]      w_sel_addr;
  logic [31:0]     w_sel_data;
  logic [31:0]     w_sel_pc;

  // Wrap-around search: lowest valid at/above the pointer wins, else lowest valid overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDXW'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDXW'(i);
        end
      end
    end
  end

  assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_xfer    = rst & ~stall & w_lo_found;
  assign w_nxt_ptr = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    req_ready  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_pc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == w_gnt_idx) begin
        w_sel_addr   = req_addr[5*i +: 5];
        w_sel_data   = req_data[32*i +: 32];
        w_sel_pc     = req_pc[32*i +: 32];
        req_ready[i] = w_xfer;
      end
    end
  end

  // Output stage: $0 writes are consumed but leave the stage untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_a3     <= '0;
      r_wd     <= '0;
      r_pc     <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_we <= w_xfer && (w_sel_addr != 5'd0);
      if (w_xfer && (w_sel_addr != 5'd0)) begin
        r_a3 <= w_sel_addr;
        r_wd <= w_sel_data;
        r_pc <= w_sel_pc;
      end
      if (w_xfer) begin
        r_rr_ptr <= w_nxt_ptr;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_a3    = r_a3;
  assign rf_wd    = r_wd;
  assign rf_pc    = r_pc;
  assign byp_hit1 = r_we && (r_a3 == byp_a1) && (byp_a1 != 5'd0);
  assign byp_hit2 = r_we && (r_a3 == byp_a2) && (byp_a2 != 5'd0);
  assign byp_data = r_wd;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, round-robin order,
// $0 writes, stall, bypass and reset mid-operation.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int IDXW = 2;

  logic               clk;
  logic               rst;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [32*NREQ-1:0] req_pc;
  logic [NREQ-1:0]    req_ready;
  logic               rf_we;
  logic [4:0]         rf_a3;
  logic [31:0]        rf_wd;
  logic [31:0]        rf_pc;
  logic [4:0]         byp_a1;
  logic [4:0]         byp_a2;
  logic               byp_hit1;
  logic               byp_hit2;
  logic [31:0]        byp_data;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .byp_a1(byp_a1), .byp_a2(byp_a2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p);
    req_addr[5*i +: 5]   = a;
    req_data[32*i +: 32] = d;
    req_pc[32*i +: 32]   = p;
  endtask

  initial begin
    rst       = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_pc    = '0;
    byp_a1    = '0;
    byp_a2    = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'hA0 + i, 32'h100 + i);

    // 1: reset held with every requester valid
    req_valid = 3'b111;
    #1;
    chk("rst_ready_comb", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_a3", 32'(rf_a3), 32'h0);
    chk("rst_wd", rf_wd, 32'h0);
    req_valid = '0;
    rst = 1'b1;
    tick();
    chk("rel_we", 32'(rf_we), 32'h0);
    chk("rel_a3", 32'(rf_a3), 32'h0);
    chk("rel_wd", rf_wd, 32'h0);
    chk("rel_pc", rf_pc, 32'h0);

    // 2: single request on req0
    set_req(0, 5'd5, 32'h1234, 32'h3000);
    req_valid = 3'b001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("single_we", 32'(rf_we), 32'h1);
    chk("single_a3", 32'(rf_a3), 32'd5);
    chk("single_wd", rf_wd, 32'h1234);
    chk("single_pc", rf_pc, 32'h3000);
    chk("single_ready_off", 32'(req_ready), 32'h0);
    tick();
    chk("single_we_off", 32'(rf_we), 32'h0);

    // pointer is now 1; reset to restart round-robin from req0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_req(0, 5'd10, 32'hA0, 32'h100);

    // 3: round-robin with all three valid
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
      tick();
      chk($sformatf("rr_we_%0d", c), 32'(rf_we), 32'h1);
      chk($sformatf("rr_a3_%0d", c), 32'(rf_a3), 32'(10 + (c % 3)));
      chk($sformatf("rr_wd_%0d", c), rf_wd, 32'hA0 + 32'(c % 3));
      chk($sformatf("rr_pc_%0d", c), rf_pc, 32'h100 + 32'(c % 3));
    end
    req_valid = '0;
    tick();
    chk("rr_we_idle", 32'(rf_we), 32'h0);

    // 4: write to $0 from req1
    set_req(1, 5'd0, 32'hFFFF, 32'h200);
    req_valid = 3'b010;
    #1;
    chk("r0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("r0_we", 32'(rf_we), 32'h0);
    chk("r0_a3_hold", 32'(rf_a3), 32'd12);
    chk("r0_wd_hold", rf_wd, 32'hA2);
    set_req(1, 5'd11, 32'hA1, 32'h101);
    req_valid = 3'b111;
    #1;
    chk("r0_next_ready", 32'(req_ready), 32'h4);
    tick();
    chk("r0_next_we", 32'(rf_we), 32'h1);
    chk("r0_next_a3", 32'(rf_a3), 32'd12);

    // 5: stall for 3 cycles while a write drains; pointer is back at 0
    req_valid = 3'b101;
    stall = 1'b1;
    #1;
    chk("st_ready_0", 32'(req_ready), 32'h0);
    chk("st_drain_we", 32'(rf_we), 32'h1);
    tick();
    chk("st_ready_1", 32'(req_ready), 32'h0);
    chk("st_we_1", 32'(rf_we), 32'h0);
    tick();
    chk("st_ready_2", 32'(req_ready), 32'h0);
    chk("st_we_2", 32'(rf_we), 32'h0);
    tick();
    stall = 1'b0;
    #1;
    chk("st_release_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("st_release_we", 32'(rf_we), 32'h1);
    chk("st_release_a3", 32'(rf_a3), 32'd10);
    tick();

    // 6: bypass on write 7 <= 0xAA (pointer at 1, req0 wins by wrap-around)
    set_req(0, 5'd7, 32'hAA, 32'h400);
    req_valid = 3'b001;
    #1;
    chk("byp_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    byp_a1 = 5'd7;
    byp_a2 = 5'd0;
    #1;
    chk("byp_we", 32'(rf_we), 32'h1);
    chk("byp_hit1", 32'(byp_hit1), 32'h1);
    chk("byp_hit2_zero", 32'(byp_hit2), 32'h0);
    chk("byp_data", byp_data, 32'hAA);
    byp_a2 = 5'd7;
    #1;
    chk("byp_hit2", 32'(byp_hit2), 32'h1);
    byp_a1 = 5'd8;
    #1;
    chk("byp_hit1_miss", 32'(byp_hit1), 32'h0);
    byp_a1 = 5'd7;
    tick();
    chk("byp_idle_hit1", 32'(byp_hit1), 32'h0);
    chk("byp_idle_hit2", 32'(byp_hit2), 32'h0);

    // reset mid-operation drops the in-flight write
    set_req(2, 5'd9, 32'h99, 32'h500);
    req_valid = 3'b100;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h4);
    tick();
    chk("mid_we", 32'(rf_we), 32'h1);
    rst = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rst_we", 32'(rf_we), 32'h0);
    chk("mid_rst_a3", 32'(rf_a3), 32'h0);
    chk("mid_rst_wd", rf_wd, 32'h0);
    chk("mid_rst_hit1", 32'(byp_hit1), 32'h0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
